// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Pure declarations: no logic, no latency, no flow control.
package timer_pkg;

    localparam int C_TIMER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } t_timer_state;

endpackage

// File: rtl/m_down_counter.sv
// Loadable down-counter that saturates at zero; load has priority over dec.
// Count updates one clk after load/dec; no backpressure, commands are always accepted.
module m_down_counter
    import timer_pkg::*;
#(
    parameter int P_WIDTH = C_TIMER_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [P_WIDTH-1:0] value,
    output logic [P_WIDTH-1:0] count,
    output logic               is_one
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == P_WIDTH'(1));

endmodule

// File: rtl/m_timer_countdown.sv
// Start/pause/abort countdown timer on prescaler ticks; all outputs registered, one clk after the deciding edge.
// No backpressure; stop beats start. Define TIMER_RELOAD_EN for periodic auto-reload on expiry.
module m_timer_countdown
    import timer_pkg::*;
#(
    parameter int P_WIDTH = C_TIMER_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               c_in,
    input  logic               start,
    input  logic               stop,
    input  logic [P_WIDTH-1:0] load_val,
    output logic [P_WIDTH-1:0] cnt,
    output logic               busy,
    output logic               c_out
);

    t_timer_state       state;
    t_timer_state       state_nxt;
    logic               ctr_load;
    logic               ctr_dec;
    logic [P_WIDTH-1:0] ctr_value;
    logic               ctr_is_one;
    logic               busy_nxt;
    logic               c_out_nxt;

`ifdef TIMER_RELOAD_EN
    logic [P_WIDTH-1:0] reload_val;
    logic               reload_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_val <= '0;
        end else if (reload_ld) begin
            reload_val <= load_val;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            c_out <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            c_out <= c_out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;
        ctr_value = '0;
        c_out_nxt = 1'b0;
`ifdef TIMER_RELOAD_EN
        reload_ld = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
`ifdef TIMER_RELOAD_EN
                    reload_ld = 1'b1;
`endif
                    // A zero load expires immediately; the count is already 0 in IDLE.
                    if (load_val != '0) begin
                        ctr_load  = 1'b1;
                        ctr_value = load_val;
                        state_nxt = RUN;
                    end else begin
                        c_out_nxt = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = PAUSE;
                end else if (c_in) begin
                    if (ctr_is_one) begin
                        c_out_nxt = 1'b1;
`ifdef TIMER_RELOAD_EN
                        ctr_load  = 1'b1;
                        ctr_value = reload_val;
`else
                        ctr_dec   = 1'b1;
                        state_nxt = DONE;
`endif
                    end else begin
                        ctr_dec = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    ctr_load  = 1'b1;
                    ctr_value = '0;
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
    end

    m_down_counter #(
        .P_WIDTH (P_WIDTH)
    ) u_down_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (ctr_load),
        .dec    (ctr_dec),
        .value  (ctr_value),
        .count  (cnt),
        .is_one (ctr_is_one)
    );

endmodule

// File: tb/tb_m_timer_countdown.sv
// Scenario bench for m_timer_countdown: per-cycle expectations queued at stimulus time, popped after the edge.
module tb_m_timer_countdown;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         c_in = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] cnt;
    logic         busy;
    logic         c_out;

    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   dbl = 0;
    logic prev_cout = 1'b0;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         busy;
        logic         c_out;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    m_timer_countdown #(.P_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .c_in     (c_in),
        .start    (start),
        .stop     (stop),
        .load_val (load_val),
        .cnt      (cnt),
        .busy     (busy),
        .c_out    (c_out)
    );

    always @(negedge clk) begin
        if (c_out) pulses++;
        if (c_out && prev_cout) dbl++;
        prev_cout = c_out;
    end

    task automatic step(input logic s, input logic p, input logic ci);
        start = s;
        stop  = p;
        c_in  = ci;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        c_in  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (cnt !== '0 || busy !== 1'b0 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL reset: got cnt=%0d busy=%b c_out=%b want 0 0 0", cnt, busy, c_out);
        end
        #10 rst = 1'b0;
    endtask

    task automatic test_oneshot();
        int p0;
        p0 = pulses;
        load_val = W'(5);
        exp_q.push_back('{cnt: W'(5), busy: 1'b1, c_out: 1'b0});
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL oneshot_start: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                exp_q.push_back('{cnt: W'(6 - k), busy: 1'b1, c_out: 1'b0});
                step(1'b0, 1'b0, 1'b0);
                e = exp_q.pop_front();
                total++;
                if ({cnt, busy, c_out} !== e) begin
                    bad++;
                    $display("FAIL oneshot_hold%0d: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", k, cnt, busy, c_out, e.cnt, e.busy, e.c_out);
                end
            end
            exp_q.push_back('{cnt: W'(5 - k), busy: (k != 5), c_out: (k == 5)});
            step(1'b0, 1'b0, 1'b1);
            e = exp_q.pop_front();
            total++;
            if ({cnt, busy, c_out} !== e) begin
                bad++;
                $display("FAIL oneshot_tick%0d: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", k, cnt, busy, c_out, e.cnt, e.busy, e.c_out);
            end
        end
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b0});
        step(1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL oneshot_idle: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL oneshot_pulses: got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_pause_resume();
        int p0;
        p0 = pulses;
        load_val = W'(10);
        step(1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 3; t++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_q.push_back('{cnt: W'(10 - t), busy: 1'b1, c_out: 1'b0});
            step(1'b0, 1'b0, 1'b1);
            e = exp_q.pop_front();
            total++;
            if ({cnt, busy, c_out} !== e) begin
                bad++;
                $display("FAIL pause_run%0d: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", t, cnt, busy, c_out, e.cnt, e.busy, e.c_out);
            end
        end
        load_val = W'(99);
        exp_q.push_back('{cnt: W'(7), busy: 1'b1, c_out: 1'b0});
        step(1'b0, 1'b1, 1'b1);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL pause_enter: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        for (int t = 1; t <= 20; t++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_q.push_back('{cnt: W'(7), busy: 1'b1, c_out: 1'b0});
            step(1'b0, 1'b0, 1'b1);
            e = exp_q.pop_front();
            total++;
            if ({cnt, busy, c_out} !== e) begin
                bad++;
                $display("FAIL pause_hold%0d: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", t, cnt, busy, c_out, e.cnt, e.busy, e.c_out);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 7; t++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_q.push_back('{cnt: W'(7 - t), busy: (t != 7), c_out: (t == 7)});
            step(1'b0, 1'b0, 1'b1);
            e = exp_q.pop_front();
            total++;
            if ({cnt, busy, c_out} !== e) begin
                bad++;
                $display("FAIL resume_tick%0d: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", t, cnt, busy, c_out, e.cnt, e.busy, e.c_out);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL pause_pulses: got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_abort();
        int p0;
        p0 = pulses;
        load_val = W'(8);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        exp_q.push_back('{cnt: W'(6), busy: 1'b1, c_out: 1'b0});
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL abort_pause: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b0});
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL abort_idle: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        load_val = W'(2);
        exp_q.push_back('{cnt: W'(2), busy: 1'b1, c_out: 1'b0});
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL abort_restart: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (pulses - p0 !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulses: got pulses=%0d busy=%b want 0 0", pulses - p0, busy);
        end
    endtask

    task automatic test_zero_priority();
        int p0;
        p0 = pulses;
        load_val = W'(0);
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b1});
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL zero_done: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        // start presented during DONE must not relaunch
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b0});
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL zero_after: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        load_val = W'(4);
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b0});
        step(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL prio_idle: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b0});
        step(1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL prio_idle_cin: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        step(1'b1, 1'b0, 1'b0);
        exp_q.push_back('{cnt: W'(4), busy: 1'b1, c_out: 1'b0});
        step(1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL prio_run: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        exp_q.push_back('{cnt: W'(4), busy: 1'b1, c_out: 1'b0});
        step(1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL prio_pause_cin: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b0});
        step(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL prio_pause: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL zero_pulses: got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_mid_reset();
        int p0;
        p0 = pulses;
        load_val = W'(100);
        step(1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 50; t++) step(1'b0, 1'b0, 1'b1);
        exp_q.push_back('{cnt: W'(50), busy: 1'b1, c_out: 1'b0});
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL midrst_count: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (cnt !== '0 || busy !== 1'b0 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: got cnt=%0d busy=%b c_out=%b want 0 0 0", cnt, busy, c_out);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        load_val = W'(3);
        exp_q.push_back('{cnt: W'(3), busy: 1'b1, c_out: 1'b0});
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL midrst_restart: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (pulses - p0 !== 0) begin
            bad++;
            $display("FAIL midrst_pulses: got %0d want 0", pulses - p0);
        end
    endtask

`ifdef TIMER_RELOAD_EN
    task automatic test_periodic();
        int p0;
        p0 = pulses;
        load_val = W'(3);
        exp_q.push_back('{cnt: W'(3), busy: 1'b1, c_out: 1'b0});
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL periodic_start: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        for (int t = 1; t <= 9; t++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_q.push_back('{cnt: ((t % 3) == 0) ? W'(3) : W'(3 - (t % 3)), busy: 1'b1, c_out: ((t % 3) == 0)});
            step(1'b0, 1'b0, 1'b1);
            e = exp_q.pop_front();
            total++;
            if ({cnt, busy, c_out} !== e) begin
                bad++;
                $display("FAIL periodic_tick%0d: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", t, cnt, busy, c_out, e.cnt, e.busy, e.c_out);
            end
        end
        exp_q.push_back('{cnt: W'(3), busy: 1'b1, c_out: 1'b0});
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL periodic_pause: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        exp_q.push_back('{cnt: W'(0), busy: 1'b0, c_out: 1'b0});
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if ({cnt, busy, c_out} !== e) begin
            bad++;
            $display("FAIL periodic_exit: got cnt=%0d busy=%b c_out=%b want cnt=%0d busy=%b c_out=%b", cnt, busy, c_out, e.cnt, e.busy, e.c_out);
        end
        total++;
        if (pulses - p0 !== 3) begin
            bad++;
            $display("FAIL periodic_pulses: got %0d want 3", pulses - p0);
        end
    endtask
`endif

    task automatic test_pulse_width();
        total++;
        if (dbl !== 0) begin
            bad++;
            $display("FAIL pulse_width: got %0d back-to-back c_out cycles want 0", dbl);
        end
    endtask

    initial begin
        test_reset();
`ifdef TIMER_RELOAD_EN
        test_periodic();
`else
        test_oneshot();
        test_pause_resume();
`endif
        test_abort();
        test_zero_priority();
        test_mid_reset();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_timer_countdown.md
M_TIMER_COUNTDOWN -- requirements
Module: m_timer_countdown

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 16, giving the counter width in ticks.
REQ-002 The block SHALL have port clk  input  1  system clock, 50 MHz.
REQ-003 The block SHALL have port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-004 The block SHALL have port c_in  input  1  one-clk-wide tick from the prescaler (1 kHz).
REQ-005 The block SHALL have port start  input  1  start from IDLE, or resume from PAUSE.
REQ-006 The block SHALL have port stop  input  1  pause from RUN, or abort from PAUSE.
REQ-007 The block SHALL have port load_val  input  P_WIDTH  initial count, sampled on start in IDLE.
REQ-008 The block SHALL have port cnt  output  P_WIDTH  current remaining count.
REQ-009 The block SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-010 The block SHALL have port c_out  output  1  expiry pulse, exactly one clk wide.

Function
REQ-011 The block SHALL implement the states IDLE, RUN, PAUSE and DONE; all outputs SHALL be registered.
REQ-012 IDLE with start=1, stop=0 and load_val!=0 SHALL load cnt<=load_val and enter RUN on the same edge.
REQ-013 IDLE with start=1, stop=0 and load_val==0 SHALL enter DONE and assert c_out for one cycle; cnt SHALL stay 0.
REQ-014 RUN with c_in=1 and stop=0 SHALL decrement cnt by 1 on that edge; RUN with c_in=0 SHALL hold cnt.
REQ-015 RUN with c_in=1, stop=0 and cnt==1 SHALL set cnt to 0, assert c_out and enter DONE on the same edge.
REQ-016 RUN with stop=1 SHALL enter PAUSE without decrementing, even if c_in=1 in that cycle.
REQ-017 PAUSE with start=1 and stop=0 SHALL return to RUN with cnt unchanged; load_val SHALL be ignored.
REQ-018 PAUSE with stop=1 SHALL clear cnt to 0 and enter IDLE without asserting c_out.
REQ-019 When start and stop are both 1 in the same cycle, stop SHALL take priority in every state.
REQ-020 c_in SHALL be ignored in IDLE, PAUSE and DONE.
REQ-021 DONE SHALL last exactly one cycle, then enter IDLE (unless REQ-027 applies); start and stop SHALL be ignored in DONE.
REQ-022 cnt SHALL never wrap below 0; c_out SHALL never be high for two consecutive cycles.
REQ-023 busy SHALL equal 1 exactly when the registered state is RUN or PAUSE.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE, cnt=0, busy=0 and c_out=0 asynchronously.
REQ-025 Reset mid-count SHALL abort with no c_out pulse.
REQ-026 After rst deasserts, the first start SHALL be honoured on the first clock edge.

Configuration
REQ-027 With macro TIMER_RELOAD_EN defined, start in IDLE SHALL also latch load_val into a reload register.
  - On expiry the block SHALL assert c_out, set cnt to the reload value and stay in RUN; DONE is not entered.
  - stop-then-stop (PAUSE -> IDLE) SHALL be the only exit from this periodic mode.
  - If load_val==0 is latched, the block SHALL behave as in REQ-013 and not enter RUN.
REQ-028 Without TIMER_RELOAD_EN, no reload register SHALL exist and behaviour SHALL be one-shot per REQ-015/REQ-021.

Structure
REQ-029 Package timer_pkg SHALL hold the state enum t_timer_state (IDLE, RUN, PAUSE, DONE) and the constant C_TIMER_WIDTH=16.
REQ-030 Sub-module m_down_counter SHALL provide the loadable down-counter: load, dec and value inputs; count and is_one outputs.
REQ-031 m_timer_countdown SHALL contain the FSM and output registers and SHALL instantiate m_down_counter once.

Verification
REQ-032 The bench SHALL cover one-shot expiry:
  - Stimulus: load_val=5, start pulse, c_in pulsed every 4 clk.
  - Response: cnt steps 5,4,3,2,1,0; c_out high one cycle, coincident with cnt=0; busy falls in the DONE cycle.
REQ-033 The bench SHALL cover pause and resume:
  - Stimulus: load_val=10; stop after 3 ticks, with c_in=1 in the same cycle; 20 more ticks; then start.
  - Response: cnt holds 7 throughout PAUSE; after resume it reaches 0 after 7 more ticks.
REQ-034 The bench SHALL cover abort:
  - Stimulus: stop in RUN, then stop in PAUSE.
  - Response: cnt=0, state IDLE, busy=0, and c_out stays 0.
REQ-035 The bench SHALL cover the zero load and the start/stop priority:
  - Stimulus: load_val=0 with start; separately, start and stop together in IDLE.
  - Response: one c_out pulse with busy never high; start+stop together in IDLE leaves the block in IDLE.
REQ-036 The bench SHALL cover reset mid-count:
  - Stimulus: load_val=100; assert rst asynchronously between clock edges after 50 ticks.
  - Response: cnt=0 and busy=0 before the next clk edge; no c_out pulse.
REQ-037 With TIMER_RELOAD_EN defined, the bench SHALL cover periodic mode:
  - Stimulus: load_val=3.
  - Response: c_out pulses on ticks 3, 6 and 9; cnt sequence 3,2,1,3,2,1...; busy stays 1 until stop, stop.
